mem_port_arbiter: RTL and testbench

- Sequences and shares the single-ported unified memory between the fetch stage (read-only) and the memory stage (read/write).
- Holds off all accesses for a fixed warm-up window after reset, then arbitrates one access at a time through a fixed state machine.
- Uses data-first priority with a starvation guard for fetch.
- Sits between the pipeline fetch/memory stages and the memory model.

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data stage.
// Data-first arbitration with a starvation guard for fetch; all outputs registered.
module mem_port_arbiter #(
    parameter int unsigned AW            = 16,
    parameter int unsigned DW            = 16,
    parameter int unsigned WARMUP_CYCLES = 2,
    parameter int unsigned STARVE_MAX    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_wr,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_done,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done,
    output logic          warm,
    output logic          busy
);

    typedef enum logic [2:0] {StWarmup, StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [3:0] WarmLast  = 4'(WARMUP_CYCLES - 1);
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    state_e        state_q, state_d;
    logic [3:0]    warm_cnt_q, warm_cnt_d;
    logic [3:0]    starve_q, starve_d;
    logic          owner_q, owner_d;  // 1: data stage owns the access
    logic          if_done_q, if_done_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic          dm_done_q, dm_done_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_wr_q, mem_wr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          warm_q, warm_d;
    logic          busy_q, busy_d;
    logic          grant_data;

    always_comb begin
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        starve_d    = starve_q;
        owner_d     = owner_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        if_rdata_d  = '0;
        dm_done_d   = 1'b0;
        dm_rdata_d  = '0;
        grant_data  = 1'b0;

        unique case (state_q)
            StWarmup: begin
                if (warm_cnt_q == WarmLast) begin
                    state_d = StIdle;
                end else begin
                    warm_cnt_d = warm_cnt_q + 4'd1;
                end
            end
            StIdle: begin
                if (if_req || dm_req) begin
                    grant_data = dm_req && (!if_req || (starve_q < StarveMax));
                    state_d    = StIssue;
                    if (grant_data) begin
                        owner_d     = 1'b1;
                        mem_wr_d    = dm_wr;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        // Only a bypassed fetch counts toward starvation
                        if (if_req) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else begin
                        owner_d     = 1'b0;
                        mem_wr_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        starve_d    = '0;
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (mem_done) begin
                    state_d = StResp;
                    if (owner_q) begin
                        dm_done_d  = 1'b1;
                        dm_rdata_d = mem_wr_q ? '0 : mem_rdata;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StWarmup;
            end
        endcase

        mem_en_d = (state_d == StIssue);
        busy_d   = (state_d == StIssue) || (state_d == StWait) || (state_d == StResp);
        warm_d   = (state_d != StWarmup);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StWarmup;
            warm_cnt_q  <= '0;
            starve_q    <= '0;
            owner_q     <= 1'b0;
            if_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_done_q   <= 1'b0;
            dm_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            warm_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            if_done_q   <= if_done_d;
            if_rdata_q  <= if_rdata_d;
            dm_done_q   <= dm_done_d;
            dm_rdata_q  <= dm_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            warm_q      <= warm_d;
            busy_q      <= busy_d;
        end
    end

    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_done   = dm_done_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign warm      = warm_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle-by-cycle vector table, then arbitration
// fairness and idle-hold sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_done;
    logic [15:0] if_rdata;
    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_done;
    logic [15:0] dm_rdata;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        warm;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_wr     (dm_wr),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_done   (dm_done),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .warm      (warm),
        .busy      (busy)
    );

    typedef struct {
        logic        rst;
        logic        if_req;
        logic [15:0] if_addr;
        logic        dm_req;
        logic        dm_wr;
        logic [15:0] dm_addr;
        logic [15:0] dm_wdata;
        logic        mem_done;
        logic [15:0] mem_rdata;
        logic [69:0] exp;
    } vec_t;

    vec_t vq[$];

    // Inputs for one cycle, then the outputs expected after the next clock edge:
    // warm, busy, mem_en, mem_wr, mem_addr, mem_wdata, if_done, if_rdata, dm_done, dm_rdata
    task automatic v(input logic r, iq, input logic [15:0] ia, input logic dq, dw,
                     input logic [15:0] da, dd, input logic md, input logic [15:0] mr,
                     input logic ew, eb, ee, er, input logic [15:0] ea, ed,
                     input logic eid, input logic [15:0] eir,
                     input logic edd, input logic [15:0] edr);
        vec_t t;
        t.rst       = r;
        t.if_req    = iq;
        t.if_addr   = ia;
        t.dm_req    = dq;
        t.dm_wr     = dw;
        t.dm_addr   = da;
        t.dm_wdata  = dd;
        t.mem_done  = md;
        t.mem_rdata = mr;
        t.exp       = {ew, eb, ee, er, ea, ed, eid, eir, edd, edr};
        vq.push_back(t);
    endtask

    function automatic logic [69:0] outs();
        return {warm, busy, mem_en, mem_wr, mem_addr, mem_wdata,
                if_done, if_rdata, dm_done, dm_rdata};
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          grants;
        int          ens;
        logic        wait_next;
        logic [7:0]  exp_data;
        logic [15:0] rd;

        rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_wr = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_done = 1'b0; mem_rdata = '0;

        // Warm-up with fetch pending from the start, then the fetch itself
        v(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
          1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        v(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
          1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        v(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
          1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        v(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
          1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        v(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
          1'b1, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        v(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
          1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        v(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF,
          1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'h0000);
        v(1'b0, 1'b0, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
          1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        // Data write; mem_done during ISSUE and operand changes after grant are ignored
        v(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'h1234, 1'b0, 16'h0000,
          1'b1, 1'b1, 1'b1, 1'b1, 16'h0100, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000);
        v(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'h1234, 1'b1, 16'h5555,
          1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000);
        v(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0FFF, 16'hAAAA, 1'b0, 16'h0000,
          1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000);
        v(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0FFF, 16'hAAAA, 1'b0, 16'h0000,
          1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000);
        v(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'h1234, 1'b1, 16'h5555,
          1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 16'h1234, 1'b0, 16'h0000, 1'b1, 16'h0000);
        v(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
          1'b1, 1'b0, 1'b0, 1'b1, 16'h0100, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000);
        // Data read
        v(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h9999, 1'b0, 16'h0000,
          1'b1, 1'b1, 1'b1, 1'b0, 16'h0200, 16'h9999, 1'b0, 16'h0000, 1'b0, 16'h0000);
        v(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h9999, 1'b0, 16'h0000,
          1'b1, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h9999, 1'b0, 16'h0000, 1'b0, 16'h0000);
        v(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h9999, 1'b1, 16'hCAFE,
          1'b1, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h9999, 1'b0, 16'h0000, 1'b1, 16'hCAFE);
        v(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
          1'b1, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h9999, 1'b0, 16'h0000, 1'b0, 16'h0000);
        // Reset during WAIT, late mem_done, then a full warm-up before the retry
        v(1'b0, 1'b1, 16'h0300, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
          1'b1, 1'b1, 1'b1, 1'b0, 16'h0300, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        v(1'b0, 1'b1, 16'h0300, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
          1'b1, 1'b1, 1'b0, 1'b0, 16'h0300, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        v(1'b1, 1'b1, 16'h0300, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
          1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        v(1'b0, 1'b1, 16'h0300, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h7777,
          1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        v(1'b0, 1'b1, 16'h0300, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
          1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        v(1'b0, 1'b1, 16'h0300, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
          1'b1, 1'b1, 1'b1, 1'b0, 16'h0300, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        v(1'b0, 1'b1, 16'h0300, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
          1'b1, 1'b1, 1'b0, 1'b0, 16'h0300, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        v(1'b0, 1'b1, 16'h0300, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1111,
          1'b1, 1'b1, 1'b0, 1'b0, 16'h0300, 16'h0000, 1'b1, 16'h1111, 1'b0, 16'h0000);
        v(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
          1'b1, 1'b0, 1'b0, 1'b0, 16'h0300, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);

        for (int i = 0; i < vq.size(); i++) begin
            rst       = vq[i].rst;
            if_req    = vq[i].if_req;
            if_addr   = vq[i].if_addr;
            dm_req    = vq[i].dm_req;
            dm_wr     = vq[i].dm_wr;
            dm_addr   = vq[i].dm_addr;
            dm_wdata  = vq[i].dm_wdata;
            mem_done  = vq[i].mem_done;
            mem_rdata = vq[i].mem_rdata;
            tick();
            check($sformatf("vec%0d", i), 80'(outs()), 80'(vq[i].exp));
        end

        // Both requesters held: expect D,D,D,F,D,D,D,F (bit i set = data grant i)
        exp_data  = 8'b0111_0111;
        grants    = 0;
        ens       = 0;
        wait_next = 1'b0;
        rd        = '0;
        if_req = 1'b1; if_addr = 16'h0A00;
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0D00; dm_wdata = 16'h0000;
        mem_done = 1'b0;
        for (int c = 0; c < 200 && grants < 8; c++) begin
            tick();
            if (mem_en) begin
                ens++;
                check($sformatf("arb_grant%0d", grants), 80'(mem_addr == 16'h0D00),
                      80'(exp_data[grants]));
            end
            if (if_done || dm_done) begin
                rd = 16'h5A00 + 16'(grants);
                check($sformatf("arb_done%0d", grants), 80'({if_done, dm_done}),
                      exp_data[grants] ? 80'(2'b01) : 80'(2'b10));
                check($sformatf("arb_rdata%0d", grants), 80'({if_rdata, dm_rdata}),
                      exp_data[grants] ? 80'({16'h0000, rd}) : 80'({rd, 16'h0000}));
                check($sformatf("arb_one_en%0d", grants), 80'(ens), 80'(1));
                ens = 0;
                grants++;
            end
            // Respond during the WAIT cycle that follows each strobe
            mem_done  = wait_next;
            mem_rdata = 16'h5A00 + 16'(grants);
            wait_next = mem_en;
        end
        check("arb_grant_count", 80'(grants), 80'(8));

        // No requests: nothing issued, last fetch operands held
        if_req = 1'b0; dm_req = 1'b0; mem_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("idle_hold%0d", c),
                  80'({mem_en, busy, warm, mem_wr, mem_addr, mem_wdata, if_done, dm_done}),
                  80'({1'b0, 1'b0, 1'b1, 1'b0, 16'h0A00, 16'h0000, 1'b0, 1'b0}));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
